// File: rtl/osyrys64_pkg.sv
// Shared definitions for the load-return path: funct3 encodings, FSM states
// and the per-load flag record kept in the metadata queue.
package osyrys64_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_ILL = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HI,
        S_OUT
    } state_e;

    // Width-independent part of a queue entry; offset and tag are packed
    // beside it by the user because their widths depend on XLEN and TAG_W.
    typedef struct packed {
        logic [2:0] f3;
        logic       split;
        logic       bad;
    } meta_flags_t;

    function automatic logic [3:0] f3_size(input logic [2:0] f3);
        return 4'd1 << f3[1:0];
    endfunction

endpackage

// File: rtl/load_meta_fifo.sv
// Circular metadata FIFO for outstanding loads, with a per-entry kill bit
// that a flush sets on every slot in one cycle.
module load_meta_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    input  logic              kill_all_i,
    output logic [DATA_W-1:0] head_data_o,
    output logic              head_kill_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              empty_o,
    output logic              full_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  kill_q;
    logic [DEPTH-1:0]  kill_d;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    // Marking free slots too is harmless: a push always clears its own slot,
    // which also keeps a request enqueued alongside a flush alive.
    always_comb begin
        kill_d = kill_all_i ? {DEPTH{1'b1}} : kill_q;
        if (push_i) begin
            kill_d[wr_ptr_q] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            kill_q   <= '0;
        end else begin
            kill_q <= kill_d;
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_data_o = mem_q[rd_ptr_q];
    assign head_kill_o = kill_q[rd_ptr_q];
    assign count_o     = count_q;
    assign empty_o     = (count_q == '0);
    assign full_o      = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/load_align_queue.sv
// In-order load return: pairs memory beats with queued load metadata, merges
// boundary-crossing loads, aligns/extends and registers the writeback result.
module load_align_queue
    import osyrys64_pkg::*;
#(
    parameter int XLEN             = 64,
    parameter int DEPTH            = 4,
    parameter int TAG_W            = 5,
    parameter int SUPPORT_MISALIGN = 1,
    localparam int NB    = XLEN / 8,
    localparam int OFF_W = $clog2(NB),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_f3,
    input  logic [OFF_W-1:0] req_offset,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             rsp_valid,
    output logic             rsp_ready,
    input  logic [XLEN-1:0]  rsp_data,
    input  logic             rsp_err,
    input  logic             flush,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [XLEN-1:0]  wb_data,
    output logic [TAG_W-1:0] wb_tag,
    output logic             wb_err,
    output logic [CNT_W-1:0] pending
);

    localparam int META_W = $bits(meta_flags_t) + OFF_W + TAG_W;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   lo_beat_q, lo_beat_d;
    logic              lo_err_q, lo_err_d;
    logic              wb_valid_q, wb_valid_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic [TAG_W-1:0]  wb_tag_q, wb_tag_d;
    logic              wb_err_q, wb_err_d;

    logic [3:0]        req_size;
    logic              req_illegal;
    logic              req_cross;
    meta_flags_t       req_flags;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic [META_W-1:0] head_data;
    logic              head_kill;
    meta_flags_t       head_flags;
    logic [OFF_W-1:0]  head_off;
    logic [TAG_W-1:0]  head_tag;
    logic              beat_acc;

    logic [2*XLEN-1:0] merged;
    logic [XLEN-1:0]   aligned;
    logic [XLEN-1:0]   extended;
    logic [XLEN-1:0]   result_data;
    logic              result_err;
    logic              sign_bit;
    int                size_bits;

    // Legality and boundary crossing are resolved at issue so the response
    // path only has to look at stored flags.
    always_comb begin
        req_size        = f3_size(req_f3);
        req_illegal     = (req_f3 == F3_ILL) || (int'(req_size) > NB);
        req_cross       = (int'(req_offset) + int'(req_size)) > NB;
        req_flags.f3    = req_f3;
        req_flags.split = (SUPPORT_MISALIGN != 0) && req_cross;
        req_flags.bad   = req_illegal || ((SUPPORT_MISALIGN == 0) && req_cross);
    end

    assign fifo_push = req_valid && req_ready;

    load_meta_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (META_W)
    ) u_meta_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (fifo_push),
        .push_data_i ({req_flags, req_offset, req_tag}),
        .pop_i       (fifo_pop),
        .kill_all_i  (flush),
        .head_data_o (head_data),
        .head_kill_o (head_kill),
        .count_o     (pending),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    assign {head_flags, head_off, head_tag} = head_data;

    assign req_ready = !fifo_full;
    assign rsp_ready = !fifo_empty && ((state_q != S_OUT) || wb_ready);
    assign beat_acc  = rsp_valid && rsp_ready;

    // In S_HI the stored low beat sits below the arriving high beat, so one
    // shifter serves both single and split loads.
    always_comb begin
        merged    = (state_q == S_HI) ? {rsp_data, lo_beat_q} : {{XLEN{1'b0}}, rsp_data};
        aligned   = XLEN'(merged >> {head_off, 3'b000});
        size_bits = 8 << head_flags.f3[1:0];
        case (head_flags.f3[1:0])
            2'd0:    sign_bit = aligned[7];
            2'd1:    sign_bit = aligned[15];
            2'd2:    sign_bit = aligned[31];
            default: sign_bit = aligned[XLEN-1];
        endcase
        sign_bit = sign_bit & ~head_flags.f3[2];
        for (int i = 0; i < XLEN; i++) begin
            extended[i] = (i < size_bits) ? aligned[i] : sign_bit;
        end
        result_err  = rsp_err || head_flags.bad || ((state_q == S_HI) && lo_err_q);
        result_data = result_err ? '0 : extended;
    end

    always_comb begin
        state_d    = state_q;
        lo_beat_d  = lo_beat_q;
        lo_err_d   = lo_err_q;
        wb_valid_d = wb_valid_q;
        wb_data_d  = wb_data_q;
        wb_tag_d   = wb_tag_q;
        wb_err_d   = wb_err_q;
        fifo_pop   = 1'b0;

        if ((state_q == S_OUT) && (wb_ready || flush)) begin
            wb_valid_d = 1'b0;
            state_d    = S_IDLE;
        end

        // A head killed now or earlier still consumes its beats, just silently.
        if (beat_acc) begin
            if ((state_q != S_HI) && head_flags.split) begin
                lo_beat_d = rsp_data;
                lo_err_d  = rsp_err;
                state_d   = S_HI;
            end else begin
                fifo_pop = 1'b1;
                if (head_kill || flush) begin
                    state_d = S_IDLE;
                end else begin
                    wb_valid_d = 1'b1;
                    wb_data_d  = result_data;
                    wb_tag_d   = head_tag;
                    wb_err_d   = result_err;
                    state_d    = S_OUT;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            lo_beat_q  <= '0;
            lo_err_q   <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_tag_q   <= '0;
            wb_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            lo_beat_q  <= lo_beat_d;
            lo_err_q   <= lo_err_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_tag_q   <= wb_tag_d;
            wb_err_q   <= wb_err_d;
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_data  = wb_data_q;
    assign wb_tag   = wb_tag_q;
    assign wb_err   = wb_err_q;

endmodule

// File: tb/tb_load_align_queue.sv
// Scoreboard bench for load_align_queue: expected results are queued at issue
// and compared when writeback presents them; a second instance has misalignment off.
module tb_load_align_queue;
    import osyrys64_pkg::*;

    localparam int XLEN  = 64;
    localparam int DEPTH = 4;
    localparam int TAG_W = 5;
    localparam int OFF_W = 3;
    localparam int CNT_W = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic             req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, flush;
    logic [2:0]       req_f3;
    logic [OFF_W-1:0] req_offset;
    logic [TAG_W-1:0] req_tag, wb_tag;
    logic [XLEN-1:0]  rsp_data, wb_data;
    logic             wb_valid, wb_ready, wb_err;
    logic [CNT_W-1:0] pending;

    logic             nm_req_valid, nm_req_ready, nm_rsp_valid, nm_rsp_ready, nm_rsp_err, nm_flush;
    logic [2:0]       nm_req_f3;
    logic [OFF_W-1:0] nm_req_offset;
    logic [TAG_W-1:0] nm_req_tag, nm_wb_tag;
    logic [XLEN-1:0]  nm_rsp_data, nm_wb_data;
    logic             nm_wb_valid, nm_wb_ready, nm_wb_err;
    logic [CNT_W-1:0] nm_pending;

    typedef struct {
        logic [XLEN-1:0]  data;
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    load_align_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .TAG_W(TAG_W), .SUPPORT_MISALIGN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_f3(req_f3),
        .req_offset(req_offset), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .flush(flush),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_tag(wb_tag),
        .wb_err(wb_err), .pending(pending)
    );

    load_align_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .TAG_W(TAG_W), .SUPPORT_MISALIGN(0)) dut_nm (
        .clk(clk), .rst_n(rst_n),
        .req_valid(nm_req_valid), .req_ready(nm_req_ready), .req_f3(nm_req_f3),
        .req_offset(nm_req_offset), .req_tag(nm_req_tag),
        .rsp_valid(nm_rsp_valid), .rsp_ready(nm_rsp_ready), .rsp_data(nm_rsp_data), .rsp_err(nm_rsp_err),
        .flush(nm_flush),
        .wb_valid(nm_wb_valid), .wb_ready(nm_wb_ready), .wb_data(nm_wb_data), .wb_tag(nm_wb_tag),
        .wb_err(nm_wb_err), .pending(nm_pending)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] f3, input logic [OFF_W-1:0] off, input logic [TAG_W-1:0] tag);
        req_valid  = 1'b1;
        req_f3     = f3;
        req_offset = off;
        req_tag    = tag;
        tick();
        req_valid  = 1'b0;
    endtask

    task automatic beat(input logic [XLEN-1:0] data, input logic err);
        rsp_valid = 1'b1;
        rsp_data  = data;
        rsp_err   = err;
        tick();
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
    endtask

    task automatic expect_result(input logic [XLEN-1:0] data, input logic [TAG_W-1:0] tag, input logic err);
        exp_t e;
        e.data = data;
        e.tag  = tag;
        e.err  = err;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 0; req_f3 = 0; req_offset = 0; req_tag = 0;
        rsp_valid = 1; rsp_data = '1; rsp_err = 0; flush = 0; wb_ready = 0;
        nm_req_valid = 0; nm_req_f3 = 0; nm_req_offset = 0; nm_req_tag = 0;
        nm_rsp_valid = 0; nm_rsp_data = 0; nm_rsp_err = 0; nm_flush = 0; nm_wb_ready = 1;
        tick();
        tick();
        checks++; if (pending !== 3'd0) begin errors++; $display("[TB] FAIL reset_pending: got %0d expected 0", pending); end
        checks++; if ({wb_valid, wb_data, wb_tag, wb_err} !== {1'b0, 64'h0, 5'h0, 1'b0}) begin
            errors++; $display("[TB] FAIL reset_wb: got v=%b d=%h t=%0d e=%b expected all zero", wb_valid, wb_data, wb_tag, wb_err); end
        checks++; if ({req_ready, rsp_ready} !== 2'b10) begin
            errors++; $display("[TB] FAIL reset_ready: got req_ready=%b rsp_ready=%b expected 1 0", req_ready, rsp_ready); end
        checks++; if (nm_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_nm_ready: got %b expected 1", nm_req_ready); end
        rsp_valid = 1'b0;
        rsp_data  = '0;
        rst_n     = 1'b1;
        tick();
        wb_ready  = 1'b1;
    endtask

    task automatic test_lw();
        exp_t e;
        expect_result(64'hFFFF_FFFF_8000_0001, 5'd3, 1'b0);
        issue(F3_LW, 3'd4, 5'd3);
        checks++; if ({pending, rsp_ready, wb_valid} !== {3'd1, 1'b1, 1'b0}) begin
            errors++; $display("[TB] FAIL lw_queued: got pending=%0d rsp_ready=%b wb_valid=%b expected 1 1 0", pending, rsp_ready, wb_valid); end
        beat(64'h8000_0001_1234_5678, 1'b0);
        e = sb.pop_front();
        checks++; if ({wb_valid, wb_data, wb_tag, wb_err} !== {1'b1, e.data, e.tag, e.err}) begin
            errors++; $display("[TB] FAIL lw_result: got v=%b d=%h t=%0d e=%b expected v=1 d=%h t=%0d e=%b", wb_valid, wb_data, wb_tag, wb_err, e.data, e.tag, e.err); end
        checks++; if (pending !== 3'd0) begin errors++; $display("[TB] FAIL lw_pending: got %0d expected 0", pending); end
        tick();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL lw_release: got wb_valid=%b expected 0", wb_valid); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        expect_result(64'h0000_0000_0000_00AB, 5'd1, 1'b0);
        expect_result(64'hFFFF_FFFF_FFFF_F00F, 5'd2, 1'b0);
        issue(F3_LBU, 3'd7, 5'd1);
        issue(F3_LH, 3'd2, 5'd2);
        rsp_valid = 1'b1;
        rsp_data  = 64'hAB00_0000_0000_0000;
        tick();
        e = sb.pop_front();
        checks++; if ({wb_valid, wb_data, wb_tag, wb_err} !== {1'b1, e.data, e.tag, e.err}) begin
            errors++; $display("[TB] FAIL b2b_first: got v=%b d=%h t=%0d e=%b expected v=1 d=%h t=%0d e=%b", wb_valid, wb_data, wb_tag, wb_err, e.data, e.tag, e.err); end
        checks++; if (rsp_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_rsp_ready: got %b expected 1", rsp_ready); end
        rsp_data = 64'h0000_0000_F00F_0000;
        tick();
        rsp_valid = 1'b0;
        e = sb.pop_front();
        checks++; if ({wb_valid, wb_data, wb_tag, wb_err} !== {1'b1, e.data, e.tag, e.err}) begin
            errors++; $display("[TB] FAIL b2b_second: got v=%b d=%h t=%0d e=%b expected v=1 d=%h t=%0d e=%b", wb_valid, wb_data, wb_tag, wb_err, e.data, e.tag, e.err); end
        tick();
        checks++; if ({wb_valid, pending} !== {1'b0, 3'd0}) begin
            errors++; $display("[TB] FAIL b2b_idle: got wb_valid=%b pending=%0d expected 0 0", wb_valid, pending); end
    endtask

    task automatic test_misalign();
        exp_t e;
        expect_result(64'h0000_6655_4433_2211, 5'd7, 1'b0);
        issue(F3_LD, 3'd6, 5'd7);
        beat(64'h2211_0000_0000_0000, 1'b0);
        checks++; if ({pending, wb_valid} !== {3'd1, 1'b0}) begin
            errors++; $display("[TB] FAIL split_lo: got pending=%0d wb_valid=%b expected 1 0", pending, wb_valid); end
        beat(64'h0000_0000_6655_4433, 1'b0);
        e = sb.pop_front();
        checks++; if ({wb_valid, wb_data, wb_tag, wb_err} !== {1'b1, e.data, e.tag, e.err}) begin
            errors++; $display("[TB] FAIL split_result: got v=%b d=%h t=%0d e=%b expected v=1 d=%h t=%0d e=%b", wb_valid, wb_data, wb_tag, wb_err, e.data, e.tag, e.err); end
        checks++; if (pending !== 3'd0) begin errors++; $display("[TB] FAIL split_pending: got %0d expected 0", pending); end
        tick();
    endtask

    task automatic test_full_stall();
        exp_t e;
        wb_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            expect_result({32'h0, 32'h9000_0000 + i}, TAG_W'(10 + i), 1'b0);
            issue(F3_LWU, 3'd0, TAG_W'(10 + i));
        end
        checks++; if ({pending, req_ready} !== {3'd4, 1'b0}) begin
            errors++; $display("[TB] FAIL full_ready: got pending=%0d req_ready=%b expected 4 0", pending, req_ready); end
        issue(F3_LB, 3'd0, 5'd31);
        checks++; if (pending !== 3'd4) begin errors++; $display("[TB] FAIL full_reject: got pending=%0d expected 4", pending); end
        rsp_valid = 1'b1;
        rsp_data  = {32'hDEAD_0000, 32'h9000_0000};
        tick();
        rsp_data  = {32'hDEAD_0001, 32'h9000_0001};
        for (int c = 0; c < 3; c++) begin
            checks++; if ({wb_valid, wb_data, wb_tag, wb_err, rsp_ready} !== {1'b1, sb[0].data, sb[0].tag, sb[0].err, 1'b0}) begin
                errors++; $display("[TB] FAIL stall_hold: cycle %0d got v=%b d=%h t=%0d e=%b rsp_ready=%b expected v=1 d=%h t=%0d e=0 rsp_ready=0",
                                   c, wb_valid, wb_data, wb_tag, wb_err, rsp_ready, sb[0].data, sb[0].tag); end
            tick();
        end
        checks++; if ({pending, req_ready} !== {3'd3, 1'b1}) begin
            errors++; $display("[TB] FAIL stall_pending: got pending=%0d req_ready=%b expected 3 1", pending, req_ready); end
        wb_ready = 1'b1;
        for (int k = 1; k < DEPTH; k++) begin
            e = sb.pop_front();
            checks++; if ({wb_valid, wb_data, wb_tag, wb_err} !== {1'b1, e.data, e.tag, e.err}) begin
                errors++; $display("[TB] FAIL drain_result: step %0d got v=%b d=%h t=%0d e=%b expected v=1 d=%h t=%0d e=%b", k, wb_valid, wb_data, wb_tag, wb_err, e.data, e.tag, e.err); end
            rsp_data = {32'hDEAD_0000 + k, 32'h9000_0000 + k};
            tick();
            checks++; if (pending !== CNT_W'(DEPTH - 1 - k)) begin
                errors++; $display("[TB] FAIL drain_pending: step %0d got %0d expected %0d", k, pending, DEPTH - 1 - k); end
        end
        rsp_valid = 1'b0;
        e = sb.pop_front();
        checks++; if ({wb_valid, wb_data, wb_tag, wb_err} !== {1'b1, e.data, e.tag, e.err}) begin
            errors++; $display("[TB] FAIL drain_last: got v=%b d=%h t=%0d e=%b expected v=1 d=%h t=%0d e=%b", wb_valid, wb_data, wb_tag, wb_err, e.data, e.tag, e.err); end
        tick();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_idle: got wb_valid=%b expected 0", wb_valid); end
    endtask

    task automatic test_flush();
        exp_t e;
        int seen;
        issue(F3_LD, 3'd6, 5'd20);
        issue(F3_LW, 3'd0, 5'd21);
        beat(64'h2211_0000_0000_0000, 1'b0);
        expect_result(64'hFFFF_FFFF_FFFF_FF80, 5'd22, 1'b0);
        flush      = 1'b1;
        req_valid  = 1'b1;
        req_f3     = F3_LB;
        req_offset = 3'd1;
        req_tag    = 5'd22;
        tick();
        flush      = 1'b0;
        req_valid  = 1'b0;
        checks++; if (pending !== 3'd3) begin errors++; $display("[TB] FAIL flush_pending: got %0d expected 3", pending); end
        seen = 0;
        beat(64'h0000_0000_6655_4433, 1'b0);
        if (wb_valid) seen++;
        beat(64'h0000_0000_1234_5678, 1'b0);
        if (wb_valid) seen++;
        checks++; if ({seen, pending} !== {32'd0, 3'd1}) begin
            errors++; $display("[TB] FAIL flush_killed: got %0d results pending=%0d expected 0 results pending=1", seen, pending); end
        beat(64'h0000_0000_0000_8000, 1'b0);
        e = sb.pop_front();
        checks++; if ({wb_valid, wb_data, wb_tag, wb_err} !== {1'b1, e.data, e.tag, e.err}) begin
            errors++; $display("[TB] FAIL flush_survivor: got v=%b d=%h t=%0d e=%b expected v=1 d=%h t=%0d e=%b", wb_valid, wb_data, wb_tag, wb_err, e.data, e.tag, e.err); end
        tick();
        wb_ready = 1'b0;
        issue(F3_LB, 3'd0, 5'd23);
        beat(64'h0000_0000_0000_0055, 1'b0);
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("[TB] FAIL flush_out_setup: got wb_valid=%b expected 1", wb_valid); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if ({wb_valid, pending} !== {1'b0, 3'd0}) begin
            errors++; $display("[TB] FAIL flush_out_clear: got wb_valid=%b pending=%0d expected 0 0", wb_valid, pending); end
        wb_ready = 1'b1;
        tick();
    endtask

    task automatic test_errors();
        exp_t e;
        expect_result(64'h0, 5'd9, 1'b1);
        expect_result(64'h0, 5'd11, 1'b1);
        expect_result(64'h0, 5'd12, 1'b1);
        issue(F3_LD, 3'd6, 5'd9);
        issue(F3_LW, 3'd0, 5'd11);
        issue(F3_ILL, 3'd0, 5'd12);
        beat(64'h2211_0000_0000_0000, 1'b0);
        beat(64'h0000_0000_6655_4433, 1'b1);
        e = sb.pop_front();
        checks++; if ({wb_valid, wb_data, wb_tag, wb_err} !== {1'b1, e.data, e.tag, e.err}) begin
            errors++; $display("[TB] FAIL err_split_hi: got v=%b d=%h t=%0d e=%b expected v=1 d=%h t=%0d e=%b", wb_valid, wb_data, wb_tag, wb_err, e.data, e.tag, e.err); end
        beat(64'h7777_7777_7777_7777, 1'b1);
        e = sb.pop_front();
        checks++; if ({wb_valid, wb_data, wb_tag, wb_err} !== {1'b1, e.data, e.tag, e.err}) begin
            errors++; $display("[TB] FAIL err_bus: got v=%b d=%h t=%0d e=%b expected v=1 d=%h t=%0d e=%b", wb_valid, wb_data, wb_tag, wb_err, e.data, e.tag, e.err); end
        beat(64'h7777_7777_7777_7777, 1'b0);
        e = sb.pop_front();
        checks++; if ({wb_valid, wb_data, wb_tag, wb_err} !== {1'b1, e.data, e.tag, e.err}) begin
            errors++; $display("[TB] FAIL err_illegal_f3: got v=%b d=%h t=%0d e=%b expected v=1 d=%h t=%0d e=%b", wb_valid, wb_data, wb_tag, wb_err, e.data, e.tag, e.err); end
        tick();
    endtask

    task automatic test_no_misalign();
        nm_req_valid  = 1'b1;
        nm_req_f3     = F3_LD;
        nm_req_offset = 3'd6;
        nm_req_tag    = 5'd9;
        tick();
        nm_req_f3     = F3_LW;
        nm_req_offset = 3'd4;
        nm_req_tag    = 5'd4;
        tick();
        nm_req_valid  = 1'b0;
        checks++; if (nm_pending !== 3'd2) begin errors++; $display("[TB] FAIL nm_pending: got %0d expected 2", nm_pending); end
        nm_rsp_valid = 1'b1;
        nm_rsp_data  = 64'h2211_0000_0000_0000;
        checks++; if (nm_rsp_ready !== 1'b1) begin errors++; $display("[TB] FAIL nm_rsp_ready: got %b expected 1", nm_rsp_ready); end
        tick();
        checks++; if ({nm_wb_valid, nm_wb_data, nm_wb_tag, nm_wb_err, nm_pending} !== {1'b1, 64'h0, 5'd9, 1'b1, 3'd1}) begin
            errors++; $display("[TB] FAIL nm_split_err: got v=%b d=%h t=%0d e=%b pending=%0d expected v=1 d=0 t=9 e=1 pending=1",
                               nm_wb_valid, nm_wb_data, nm_wb_tag, nm_wb_err, nm_pending); end
        nm_rsp_data = 64'h8000_0001_1234_5678;
        tick();
        nm_rsp_valid = 1'b0;
        checks++; if ({nm_wb_valid, nm_wb_data, nm_wb_tag, nm_wb_err} !== {1'b1, 64'hFFFF_FFFF_8000_0001, 5'd4, 1'b0}) begin
            errors++; $display("[TB] FAIL nm_aligned: got v=%b d=%h t=%0d e=%b expected v=1 d=ffffffff80000001 t=4 e=0",
                               nm_wb_valid, nm_wb_data, nm_wb_tag, nm_wb_err); end
        tick();
    endtask

    task automatic test_reset_mid();
        issue(F3_LW, 3'd0, 5'd5);
        issue(F3_LW, 3'd0, 5'd6);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({pending, wb_valid, req_ready} !== {3'd0, 1'b0, 1'b1}) begin
            errors++; $display("[TB] FAIL reset_mid: got pending=%0d wb_valid=%b req_ready=%b expected 0 0 1", pending, wb_valid, req_ready); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_lw();
        test_back_to_back();
        test_misalign();
        test_full_stall();
        test_flush();
        test_errors();
        test_no_misalign();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
